qspi_pad_ctrl: RTL and testbench

- Parametrised pad-side I/O controller between the QSPI peripheral core and the per-lane tri-state pad buffers (T=1 input, T=0 output).
- Supports single, dual, quad and octal lane modes.
- Enforces bus-turnaround guard cycles before any lane starts driving.
- Provides a programmable-delay input sampling pipeline that compensates pad/flash round-trip delay at high SCLK rates.

---
 rtl/qspi_pad_ctrl.sv | 124 ++++++++++++
 tb/tb_qspi_pad_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/qspi_pad_ctrl.sv
// qspi_pad_ctrl: lane-mode pad tri-state control with turnaround guard and delay-compensated receive sampling
module qspi_pad_ctrl #(
  parameter int LANES = 4,
  parameter int TURNAROUND = 1,
  parameter int SAMPLE_DLY_MAX = 3
) (
  input  logic                                  clk_i,
  input  logic                                  reset_ni,
  input  logic [1:0]                            mode_i,
  input  logic                                  dir_i,
  input  logic [LANES-1:0]                      core_data_i,
  input  logic                                  sample_strobe_i,
  input  logic [$clog2(SAMPLE_DLY_MAX+1)-1:0]   sample_dly_i,
  output logic [LANES-1:0]                      core_data_o,
  output logic                                  core_valid_o,
  output logic                                  busy_o,
  output logic [LANES-1:0]                      pad_data_o,
  output logic [LANES-1:0]                      pad_data_oen_o,
  input  logic [LANES-1:0]                      pad_data_i
);
  localparam int DW = $clog2(SAMPLE_DLY_MAX + 1);
  localparam int CW = TURNAROUND > 1 ? $clog2(TURNAROUND) : 1;
  localparam logic [CW-1:0] TURN_INIT = CW'(TURNAROUND > 0 ? TURNAROUND - 1 : 0);
  typedef enum logic [1:0] {IDLE, TURN, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [2:0] cfg, cfg_q, cfg_d, tgt_q, tgt_d;
  logic [LANES-1:0] mask_q, mask_d, new_mask, lvl, pad_q, ir_q, rx_map, data_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SAMPLE_DLY_MAX:0] sh_q;
  logic [DW-1:0] dly;
  logic acc, valid_q;
  // cfg is {mode, dir}; lane1 stays MISO in single mode regardless of dir
  function automatic logic [LANES-1:0] mask_of(input logic [2:0] c);
    logic [LANES-1:0] m;
    m = '0;
    m[3:0] = c[2:1] == 2'd0 ? 4'b1101 : c[2:1] == 2'd1 ? (c[0] ? 4'b1111 : 4'b1100) : {4{c[0]}};
    if (c[2:1] == 2'd3) m = {LANES{c[0]}};
    return m;
  endfunction
  assign cfg = {(LANES == 4 && mode_i == 2'd3) ? 2'd2 : mode_i, dir_i};
  assign new_mask = mask_of(cfg);
  always_comb begin
    state_d = state_q;
    cfg_d = cfg_q;
    tgt_d = tgt_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      tgt_d = cfg;
      if (TURNAROUND == 0) begin
        state_d = ACTIVE;
        cfg_d = cfg;
        mask_d = new_mask;
      end else begin
        state_d = TURN;
        mask_d = '0;
        cnt_d = TURN_INIT;
      end
    end else if (state_q == ACTIVE) begin
      if (cfg != cfg_q) begin
        tgt_d = cfg;
        if (TURNAROUND == 0 || (new_mask & ~mask_q) == '0) begin
          cfg_d = cfg;
          mask_d = new_mask;
        end else begin
          state_d = TURN;
          mask_d = mask_q & new_mask;
          cnt_d = TURN_INIT;
        end
      end
    end else if (cfg != tgt_q) begin
      tgt_d = cfg;
      mask_d = mask_q & new_mask;
      cnt_d = TURN_INIT;
    end else if (cnt_q == '0) begin
      state_d = ACTIVE;
      cfg_d = tgt_q;
      mask_d = mask_of(tgt_q);
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end
  // WP# and HOLD# must stay high whenever lanes 2,3 are not data lanes
  always_comb begin
    lvl = core_data_i;
    if (cfg_d[2:1] < 2'd2) lvl[3:2] = 2'b11;
  end
  assign acc = sample_strobe_i && state_q != IDLE &&
               (cfg_q[2:1] == 2'd0 || (state_q == ACTIVE && !cfg_q[0]));
  assign dly = {1'b0, sample_dly_i} > (DW+1)'(SAMPLE_DLY_MAX) ? DW'(SAMPLE_DLY_MAX) : sample_dly_i;
  assign rx_map = cfg_q[2:1] == 2'd0 ? LANES'(ir_q[1]) :
                  cfg_q[2:1] == 2'd1 ? LANES'(ir_q[1:0]) :
                  cfg_q[2:1] == 2'd2 ? LANES'(ir_q[3:0]) : ir_q;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cfg_q <= '0;
      tgt_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      pad_q <= '0;
      ir_q <= '0;
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q <= cfg_d;
      tgt_q <= tgt_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      pad_q <= lvl & mask_d;
      ir_q <= pad_data_i;
      sh_q <= {sh_q[SAMPLE_DLY_MAX-1:0], acc};
      valid_q <= sh_q[dly];
      if (sh_q[dly]) data_q <= rx_map;
    end
  end
  assign pad_data_o = pad_q;
  assign pad_data_oen_o = ~mask_q;
  assign core_data_o = data_q;
  assign core_valid_o = valid_q;
  assign busy_o = state_q != ACTIVE;
endmodule

// File: tb/tb_qspi_pad_ctrl.sv
// tb_qspi_pad_ctrl: directed checks of lane masks, turnaround guard and receive sampling latency
module tb_qspi_pad_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic [1:0] mode4, mode8, dly4;
  logic dir4, dir8, stb4, stb8, val4, val8, busy4, busy8;
  logic [3:0] cd4, pi4, po4, oen4, cdo4;
  logic [7:0] cd8, pi8, po8, oen8, cdo8;
  logic [2:0] dly8;
  int n_cmp = 0;
  int n_err = 0;
  qspi_pad_ctrl #(.LANES(4), .TURNAROUND(1), .SAMPLE_DLY_MAX(3)) u4 (
    .clk_i(clk), .reset_ni(rst_n), .mode_i(mode4), .dir_i(dir4), .core_data_i(cd4),
    .sample_strobe_i(stb4), .sample_dly_i(dly4), .core_data_o(cdo4), .core_valid_o(val4),
    .busy_o(busy4), .pad_data_o(po4), .pad_data_oen_o(oen4), .pad_data_i(pi4));
  qspi_pad_ctrl #(.LANES(8), .TURNAROUND(2), .SAMPLE_DLY_MAX(5)) u8 (
    .clk_i(clk), .reset_ni(rst_n), .mode_i(mode8), .dir_i(dir8), .core_data_i(cd8),
    .sample_strobe_i(stb8), .sample_dly_i(dly8), .core_data_o(cdo8), .core_valid_o(val8),
    .busy_o(busy8), .pad_data_o(po8), .pad_data_oen_o(oen8), .pad_data_i(pi8));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    mode4 = 2'd2; dir4 = 1'b1; cd4 = 4'hA; pi4 = 4'h0; stb4 = 1'b0; dly4 = 2'd0;
    mode8 = 2'd3; dir8 = 1'b0; cd8 = 8'h3C; pi8 = 8'h00; stb8 = 1'b0; dly8 = 3'd0;
    tick(); tick();
    chk("rst_busy4", busy4, 1); chk("rst_oen4", oen4, 4'hF); chk("rst_pad4", po4, 4'h0);
    chk("rst_data4", cdo4, 4'h0); chk("rst_valid4", val4, 0); chk("rst_oen8", oen8, 8'hFF);
    chk("rst_busy8", busy8, 1);
    rst_n = 1'b1;
    #1;
    chk("idle_busy", busy4, 1); chk("idle_oen", oen4, 4'hF);
    tick();
    chk("turn_busy", busy4, 1); chk("turn_oen", oen4, 4'hF);
    tick();
    chk("act_busy", busy4, 0); chk("act_oen", oen4, 4'h0); chk("act_pad", po4, 4'hA);
    chk("u8_turn_busy", busy8, 1);
    tick();
    chk("u8_act_busy", busy8, 0); chk("u8_rx_oen", oen8, 8'hFF);
    dir4 = 1'b0;
    tick();
    chk("q_rx_oen", oen4, 4'hF); chk("q_rx_busy", busy4, 0);
    dly4 = 2'd2; pi4 = 4'h3; stb4 = 1'b1;
    tick();
    stb4 = 1'b0; pi4 = 4'h9;
    tick();
    pi4 = 4'h5;
    tick();
    pi4 = 4'h6; chk("d2_early", val4, 0);
    tick();
    chk("d2_valid", val4, 1); chk("d2_data", cdo4, 4'h5);
    dly4 = 2'd1; stb4 = 1'b1; pi4 = 4'h0;
    tick();
    chk("d2_pulse_end", val4, 0);
    pi4 = 4'h2;
    tick();
    stb4 = 1'b0; pi4 = 4'h4;
    tick();
    pi4 = 4'h0; chk("b2b_v1", val4, 1); chk("b2b_d1", cdo4, 4'h2);
    tick();
    chk("b2b_v2", val4, 1); chk("b2b_d2", cdo4, 4'h4);
    tick();
    chk("b2b_end", val4, 0);
    dir4 = 1'b1;
    tick();
    chk("rev_oen", oen4, 4'hF); chk("rev_busy", busy4, 1);
    tick();
    chk("rev_done_oen", oen4, 4'h0); chk("rev_done_busy", busy4, 0); chk("rev_pad", po4, 4'hA);
    stb4 = 1'b1; dly4 = 2'd0;
    tick();
    stb4 = 1'b0;
    tick();
    chk("tx_strobe_ignored", val4, 0);
    mode4 = 2'd0; cd4 = 4'h1;
    tick();
    chk("single_oen", oen4, 4'h2); chk("single_pad", po4, 4'hD); chk("single_busy", busy4, 0);
    pi4 = 4'h2; stb4 = 1'b1;
    tick();
    stb4 = 1'b0; pi4 = 4'h0;
    tick();
    chk("single_valid", val4, 1); chk("single_data", cdo4, 4'h1);
    mode4 = 2'd1; dir4 = 1'b0;
    tick();
    chk("dual_oen", oen4, 4'h3); chk("dual_pad", po4, 4'hC); chk("dual_busy", busy4, 0);
    pi4 = 4'h6; stb4 = 1'b1;
    tick();
    stb4 = 1'b0;
    tick();
    chk("dual_valid", val4, 1); chk("dual_data", cdo4, 4'h2);
    dly8 = 3'd7; stb8 = 1'b1;
    tick();
    stb8 = 1'b0;
    repeat (3) tick();
    tick();
    pi8 = 8'hA5;
    tick();
    pi8 = 8'h00; chk("clamp_early", val8, 0);
    tick();
    chk("clamp_valid", val8, 1); chk("clamp_data", cdo8, 8'hA5);
    dir8 = 1'b1;
    tick();
    chk("oct_turn_busy", busy8, 1); chk("oct_turn_oen", oen8, 8'hFF);
    mode8 = 2'd2;
    tick();
    chk("retgt_busy", busy8, 1); chk("retgt_oen", oen8, 8'hFF);
    tick();
    chk("restart_busy", busy8, 1); chk("restart_oen", oen8, 8'hFF);
    tick();
    chk("quad8_busy", busy8, 0); chk("quad8_oen", oen8, 8'hF0); chk("quad8_pad", po8, 8'h0C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
